sudoku_grid_stream_loader: RTL

- Parametrised loader that turns a UART byte stream into a complete p_BOX²×p_BOX² Sudoku grid of one-hot candidate masks.
- Sits between UART_RX (upstream byte strobe) and the solver core (downstream grid plus done/ack handshake).
- All logic runs in the system clock domain.
- Adds the following, none of which earlier grid readers had:
  - empty-cell characters
  - whitespace skipping
  - error detection
  - hex digits for 16×16 grids
  - clean reload

---
 rtl/sudoku_pkg.sv | 30 +++
 rtl/sudoku_char_decoder.sv | 34 +++
 rtl/sudoku_grid_stream_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku grid stream loader and its
// companion character decoder.
package sudoku_pkg;

  typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERROR} state_t;
  typedef enum logic [1:0] {CH_DIGIT, CH_EMPTY, CH_SKIP, CH_BAD} ch_class_t;

  // Digits per row/column.
  function automatic int f_n(input int box);
    return box * box;
  endfunction

  // Cells per grid.
  function automatic int f_cells(input int box);
    return box * box * box * box;
  endfunction

  // Width of the packed grid of one-hot masks.
  function automatic int f_grid_w(input int box);
    return f_cells(box) * box * box;
  endfunction

  // Box-major cell position: whole boxes first, then row-major inside a box.
  function automatic int cell_index(input int row, input int col, input int box);
    int n;
    n = box * box;
    return ((row / box) * box + col / box) * n + (row % box) * box + col % box;
  endfunction

endpackage

// File: rtl/sudoku_char_decoder.sv
// Classifies one ASCII byte as a digit (with value), an empty cell, a
// separator to skip, or an illegal character. Digits above n are illegal.
module sudoku_char_decoder
  import sudoku_pkg::*;
(
  input  logic [7:0] rx_byte,
  input  logic [4:0] n,
  output ch_class_t  cls,
  output logic [4:0] value
);

  // Value extraction first, then class from value or the fixed byte set.
  always_comb begin
    cls   = CH_BAD;
    value = '0;
    if (rx_byte >= 8'h31 && rx_byte <= 8'h39)
      value = 5'(rx_byte - 8'h30);
    else if (rx_byte >= 8'h41 && rx_byte <= 8'h47)
      value = 5'(rx_byte - 8'h41 + 8'd10);
    else if (rx_byte >= 8'h61 && rx_byte <= 8'h67)
      value = 5'(rx_byte - 8'h61 + 8'd10);

    if (value != 5'd0) begin
      cls = (value <= n) ? CH_DIGIT : CH_BAD;
    end else begin
      case (rx_byte)
        8'h30, 8'h2E:                      cls = CH_EMPTY;  // '0' '.'
        8'h20, 8'h09, 8'h0D, 8'h0A, 8'h2C: cls = CH_SKIP;   // SP TAB CR LF ','
        default:                           cls = CH_BAD;
      endcase
    end
  end

endmodule

// File: rtl/sudoku_grid_stream_loader.sv
// Turns a UART byte stream into a box-major grid of one-hot candidate
// masks. Optional macro SUDOKU_LOADER_FULL_MASK_EN writes empty cells as
// all-ones instead of zero.
module sudoku_grid_stream_loader
  import sudoku_pkg::*;
#(
  parameter  int p_BOX      = 3,
  parameter  int p_ERR_STOP = 1,
  localparam int N          = f_n(p_BOX),
  localparam int CELLS      = f_cells(p_BOX),
  localparam int GRID_W     = f_grid_w(p_BOX),
  localparam int CNT_W      = $clog2(CELLS + 1)
)(
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Rx_Valid,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Ack,
  output logic [GRID_W-1:0] o_Grid,
  output logic              o_Done,
  output logic              o_Error,
  output logic [CNT_W-1:0]  o_Cell_Count,
  output logic [7:0]        o_Bad_Count
);

  localparam int RC_W  = $clog2(N);
  localparam int IDX_W = $clog2(GRID_W);

  state_t           state;
  logic [RC_W-1:0]  row;
  logic [RC_W-1:0]  col;
  ch_class_t        cls;
  logic [4:0]       value;
  logic [N-1:0]     mask;
  logic [IDX_W-1:0] base;

  sudoku_char_decoder u_dec (
    .rx_byte (i_Rx_Byte),
    .n       (5'(N)),
    .cls     (cls),
    .value   (value)
  );

  // Mask for the incoming cell; empty cells depend on the build option.
  always_comb begin
    mask = '0;
    if (cls == CH_DIGIT)
      mask = N'(1) << (value - 5'd1);
`ifdef SUDOKU_LOADER_FULL_MASK_EN
    else if (cls == CH_EMPTY)
      mask = '1;
`endif
  end

  // Bit offset of the current (row,col) cell in the packed grid.
  always_comb base = IDX_W'(cell_index(int'(row), int'(col), p_BOX) * N);

  // Loader FSM: writes cells in S_LOAD, holds in S_DONE/S_ERROR until ack.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= S_LOAD;
      row          <= '0;
      col          <= '0;
      o_Grid       <= '0;
      o_Done       <= 1'b0;
      o_Error      <= 1'b0;
      o_Cell_Count <= '0;
      o_Bad_Count  <= '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (i_Rx_Valid) begin
            case (cls)
              CH_DIGIT, CH_EMPTY: begin
                o_Grid[base +: N] <= mask;
                o_Cell_Count      <= o_Cell_Count + CNT_W'(1);
                if (col == RC_W'(N - 1)) begin
                  col <= '0;
                  row <= row + RC_W'(1);
                end else begin
                  col <= col + RC_W'(1);
                end
                if (o_Cell_Count == CNT_W'(CELLS - 1)) begin
                  state  <= S_DONE;
                  o_Done <= 1'b1;
                end
              end
              CH_BAD: begin
                if (p_ERR_STOP != 0) begin
                  state   <= S_ERROR;
                  o_Error <= 1'b1;
                end else if (o_Bad_Count != 8'hFF) begin
                  o_Bad_Count <= o_Bad_Count + 8'd1;
                end
              end
              default: ;  // separators consume nothing
            endcase
          end
        end
        S_DONE, S_ERROR: begin
          // Any byte arriving here, even on the ack edge, is dropped.
          if (i_Ack) begin
            state        <= S_LOAD;
            row          <= '0;
            col          <= '0;
            o_Grid       <= '0;
            o_Done       <= 1'b0;
            o_Error      <= 1'b0;
            o_Cell_Count <= '0;
            o_Bad_Count  <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
